// File: rtl/mem_dp_byte_sync.sv
// mem_dp_byte_sync: synchronous dual-port byte-addressed RAM.
// Each port does WORD_BYTES-byte accesses at any byte address. Byte order is
// big-endian and addresses wrap at the top of the array. Writes use per-byte
// enables. Reads are registered (1-cycle latency) and come with an rvalid strobe.
// After reset, a clear sequencer zeroes the array one aligned row per cycle.
// While it runs, busy is high and both ports are ignored.
// Ports:
//   clk, rst              clock, async active-high reset
//   busy                  clear sequence in progress
//   {a,b}_req/_we         request, 1 = write
//   {a,b}_addr            byte address of the MSB byte
//   {a,b}_wdata/_ben      write word (big-endian), byte enables (msb = byte at addr)
//   {a,b}_rdata/_rvalid   registered read word, one-cycle strobe
module mem_dp_byte_sync #(
  parameter int ADDR_W     = 16,
  parameter int WORD_BYTES = 2,
  parameter int BYTE_W     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         busy,
  input  logic                         a_req,
  input  logic                         a_we,
  input  logic [ADDR_W-1:0]            a_addr,
  input  logic [WORD_BYTES*BYTE_W-1:0] a_wdata,
  input  logic [WORD_BYTES-1:0]        a_ben,
  output logic [WORD_BYTES*BYTE_W-1:0] a_rdata,
  output logic                         a_rvalid,
  input  logic                         b_req,
  input  logic                         b_we,
  input  logic [ADDR_W-1:0]            b_addr,
  input  logic [WORD_BYTES*BYTE_W-1:0] b_wdata,
  input  logic [WORD_BYTES-1:0]        b_ben,
  output logic [WORD_BYTES*BYTE_W-1:0] b_rdata,
  output logic                         b_rvalid
);
  localparam int DW    = WORD_BYTES * BYTE_W;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_BYTES);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - WORD_BYTES);

  typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

  logic [BYTE_W-1:0] mem [DEPTH];

  logic a_wr, a_rd, b_wr, b_rd;
  logic [WORD_BYTES-1:0][ADDR_W-1:0] a_baddr, b_baddr, c_baddr;
  logic [DW-1:0] a_rword, b_rword;
  logic [DW-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic          a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Next state. The pointer walks byte addresses in row-sized steps and
  // leaves CLEAR on the edge that writes the last row.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + STEP;
        if (clr_addr_q == LAST) begin
          state_d    = ST_READY;
          clr_addr_d = '0;
        end
      end
      default: ;
    endcase
  end

  // FSM outputs and request qualification.
  always_comb begin
    busy = (state_q == ST_CLEAR);
    a_wr = ~busy & a_req & a_we;
    a_rd = ~busy & a_req & ~a_we;
    b_wr = ~busy & b_req & b_we;
    b_rd = ~busy & b_req & ~b_we;
  end

  // Per-byte array addresses. Byte k is the k-th byte from the MSB. The
  // ADDR_W-bit add provides the wrap to 0.
  always_comb begin
    a_baddr = '0;
    b_baddr = '0;
    c_baddr = '0;
    for (int k = 0; k < WORD_BYTES; k++) begin
      a_baddr[k] = a_addr + ADDR_W'(k);
      b_baddr[k] = b_addr + ADDR_W'(k);
      c_baddr[k] = clr_addr_q + ADDR_W'(k);
    end
  end

  // Combinational read of the current contents. These values are captured
  // on the same edge as any write, which gives read-first behaviour.
  always_comb begin
    a_rword = '0;
    b_rword = '0;
    for (int k = 0; k < WORD_BYTES; k++) begin
      a_rword[(WORD_BYTES-1-k)*BYTE_W +: BYTE_W] = mem[a_baddr[k]];
      b_rword[(WORD_BYTES-1-k)*BYTE_W +: BYTE_W] = mem[b_baddr[k]];
    end
  end

  // Array writes. Port B's writes come first so that port A's later
  // nonblocking assignment wins when both ports write the same byte.
  always_ff @(posedge clk) begin
    if (busy) begin
      for (int k = 0; k < WORD_BYTES; k++)
        mem[c_baddr[k]] <= '0;
    end else begin
      for (int k = 0; k < WORD_BYTES; k++)
        if (b_wr && b_ben[WORD_BYTES-1-k])
          mem[b_baddr[k]] <= b_wdata[(WORD_BYTES-1-k)*BYTE_W +: BYTE_W];
      for (int k = 0; k < WORD_BYTES; k++)
        if (a_wr && a_ben[WORD_BYTES-1-k])
          mem[a_baddr[k]] <= a_wdata[(WORD_BYTES-1-k)*BYTE_W +: BYTE_W];
    end
  end

  // Read output registers. rdata holds its value between reads.
  always_comb begin
    a_rvalid_d = a_rd;
    b_rvalid_d = b_rd;
    a_rdata_d  = a_rd ? a_rword : a_rdata_q;
    b_rdata_d  = b_rd ? b_rword : b_rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
endmodule
